// File: rtl/jk_pkg.sv
// -----------------------------------------------------------------------------
// jk_pkg -- shared definitions for the JK-flop based up/down/load counter.
//
// Contents:
//   mode_e : 2-bit operation select used on the jk_counter mode port
//            MODE_HOLD (00), MODE_UP (01), MODE_DOWN (10), MODE_LOAD (11)
// -----------------------------------------------------------------------------
package jk_pkg;

   typedef enum logic [1:0] {
      MODE_HOLD = 2'b00,
      MODE_UP   = 2'b01,
      MODE_DOWN = 2'b10,
      MODE_LOAD = 2'b11
   } mode_e;

endpackage : jk_pkg

// File: rtl/jk_cell.sv
// -----------------------------------------------------------------------------
// jk_cell -- single JK flip-flop with clock enable and synchronous reset.
//
// Parameters:
//   RESET_BIT : value q takes while rst is low
// Ports:
//   clk  in  rising-edge clock
//   rst  in  synchronous, active-low reset (overrides ce, j, k)
//   ce   in  clock enable; 0 holds the stored bit
//   j    in  J input
//   k    in  K input
//   q    out registered bit
// Truth table (ce=1): JK=00 hold, 01 reset, 10 set, 11 toggle.
// -----------------------------------------------------------------------------
module jk_cell #(
   parameter logic RESET_BIT = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic ce,
   input  logic j,
   input  logic k,
   output logic q
);

   logic q_q;
   logic q_d;

   always_comb begin
      // NOTE: give every combinational output a default before the case so no
      // path leaves it unassigned, which would infer a latch.
      q_d = q_q;
      case ({j, k})
         2'b00:   q_d = q_q;
         2'b01:   q_d = 1'b0;
         2'b10:   q_d = 1'b1;
         2'b11:   q_d = ~q_q;
         default: q_d = q_q;
      endcase
   end

   // NOTE: state is updated with non-blocking assignments so every flop
   // samples the pre-edge values, independent of block evaluation order.
   always_ff @(posedge clk) begin
      if (!rst) begin
         q_q <= RESET_BIT;
      end else if (ce) begin
         q_q <= q_d;
      end
   end

   assign q = q_q;

endmodule : jk_cell

// File: rtl/jk_counter.sv
// -----------------------------------------------------------------------------
// jk_counter -- WIDTH-bit up/down/load counter built from one jk_cell per bit.
// The next state is formed only through per-bit J/K drive:
//   hold   J=K=0
//   toggle J=K=1  (up: all lower bits 1, down: all lower bits 0)
//   load   J=load_val[i], K=~load_val[i]
//
// Parameters:
//   WIDTH     : counter width, 2..32
//   RESET_VAL : value q takes on reset
// Ports:
//   clk       in   rising-edge clock
//   rst       in   synchronous, active-low reset
//   en        in   count enable; 0 forces hold
//   mode      in   [1:0] 00 hold, 01 up, 10 down, 11 load
//   load_val  in   [WIDTH-1:0] parallel load value
//   q         out  [WIDTH-1:0] registered count
//   tc        out  terminal count (combinational from q and mode)
//   ovf       out  registered one-cycle pulse after an enabled step at tc
//
// Build option:
//   JK_COUNTER_SAT_EN defined   -> an enabled step taken at the terminal count
//                                  holds q (saturate); ovf still pulses.
//   JK_COUNTER_SAT_EN undefined -> q wraps modulo 2^WIDTH.
// -----------------------------------------------------------------------------
module jk_counter
   import jk_pkg::*;
#(
   parameter int unsigned      WIDTH     = 4,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] q,
   output logic             tc,
   output logic             ovf
);

   mode_e            mode_s;
   logic [WIDTH-1:0] up_tog;
   logic [WIDTH-1:0] dn_tog;
   logic [WIDTH-1:0] j;
   logic [WIDTH-1:0] k;
   logic             ovf_d;
   logic             ovf_q;

   assign mode_s = mode_e'(mode);

   // Ripple "all lower bits are 1 / 0" chains: bit i toggles on an up step
   // when every bit below it is 1, and on a down step when every bit is 0.
   always_comb begin
      logic lower_ones;
      logic lower_zeros;
      lower_ones  = 1'b1;
      lower_zeros = 1'b1;
      up_tog      = '0;
      dn_tog      = '0;
      for (int i = 0; i < WIDTH; i++) begin
         up_tog[i]   = lower_ones;
         dn_tog[i]   = lower_zeros;
         lower_ones  = lower_ones & q[i];
         lower_zeros = lower_zeros & ~q[i];
      end
   end

   // Terminal count looks only at q and mode, so it is valid during reset too.
   always_comb begin
      tc = 1'b0;
      if (mode_s == MODE_UP && q == {WIDTH{1'b1}}) begin
         tc = 1'b1;
      end else if (mode_s == MODE_DOWN && q == '0) begin
         tc = 1'b1;
      end
   end

   // Per-bit J/K drive; ovf is requested for any enabled step taken at tc
   // (tc is never set in load or hold, so loads cannot raise ovf).
   always_comb begin
      j     = '0;
      k     = '0;
      ovf_d = 1'b0;
      if (en) begin
         case (mode_s)
            MODE_HOLD: begin
               j = '0;
               k = '0;
            end
            MODE_UP: begin
               j     = up_tog;
               k     = up_tog;
               ovf_d = tc;
            end
            MODE_DOWN: begin
               j     = dn_tog;
               k     = dn_tog;
               ovf_d = tc;
            end
            MODE_LOAD: begin
               j = load_val;
               k = ~load_val;
            end
            default: begin
               j = '0;
               k = '0;
            end
         endcase
`ifdef JK_COUNTER_SAT_EN
         // Saturate: a step at the limit holds every bit instead of wrapping.
         if (tc) begin
            j = '0;
            k = '0;
         end
`endif
      end
   end

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      jk_cell #(
         .RESET_BIT (RESET_VAL[i])
      ) u_cell (
         .clk (clk),
         .rst (rst),
         .ce  (en),
         .j   (j[i]),
         .k   (k[i]),
         .q   (q[i])
      );
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         ovf_q <= 1'b0;
      end else begin
         ovf_q <= ovf_d;
      end
   end

   assign ovf = ovf_q;

endmodule : jk_counter

// File: tb/tb_jk_counter.sv
// -----------------------------------------------------------------------------
// tb_jk_counter -- self-checking bench for jk_counter (WIDTH=4, RESET_VAL=5).
// Directed vector table plus hand-written tc sequences, then a randomized run
// checked against an arithmetic reference model.
// Build option JK_COUNTER_SAT_EN selects the saturating expectations.
// -----------------------------------------------------------------------------
module tb_jk_counter;

`ifdef JK_COUNTER_SAT_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   localparam int RV = 5;

   logic       clk;
   logic       rst;
   logic       en;
   logic [1:0] mode;
   logic [3:0] load_val;
   logic [3:0] q;
   logic       tc;
   logic       ovf;

   int n_cmp = 0;
   int n_err = 0;

   // reference model state
   int q_m   = RV;
   int ovf_m = 0;

   typedef struct {
      string      name;
      logic       rst;
      logic       en;
      logic [1:0] mode;
      logic [3:0] lv;
      int         exp_q;
      int         exp_ovf;
      int         exp_tc;
   } vec_t;

   vec_t vecs[$];

   jk_counter #(
      .WIDTH     (4),
      .RESET_VAL (4'd5)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .mode     (mode),
      .load_val (load_val),
      .q        (q),
      .tc       (tc),
      .ovf      (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic int model_tc(input int qv, input int m);
      return ((m == 1 && qv == 15) || (m == 2 && qv == 0)) ? 1 : 0;
   endfunction

   // Apply inputs mid-cycle, advance the model, sample #1 after the edge.
   task automatic step(input logic r, input logic e, input logic [1:0] m,
                       input logic [3:0] lv);
      @(negedge clk);
      rst      = r;
      en       = e;
      mode     = m;
      load_val = lv;
      if (!r) begin
         q_m   = RV;
         ovf_m = 0;
      end else if (e && m == 2'b01) begin
         ovf_m = (q_m == 15) ? 1 : 0;
         if (!(SAT && q_m == 15)) q_m = (q_m + 1) % 16;
      end else if (e && m == 2'b10) begin
         ovf_m = (q_m == 0) ? 1 : 0;
         if (!(SAT && q_m == 0)) q_m = (q_m + 15) % 16;
      end else if (e && m == 2'b11) begin
         q_m   = int'(lv);
         ovf_m = 0;
      end else begin
         ovf_m = 0;
      end
      @(posedge clk);
      #1;
   endtask

   function automatic void add(input string nm, input logic r, input logic e,
                               input logic [1:0] m, input logic [3:0] lv,
                               input int eq, input int eo, input int et);
      vec_t v;
      v.name = nm; v.rst = r; v.en = e; v.mode = m; v.lv = lv;
      v.exp_q = eq; v.exp_ovf = eo; v.exp_tc = et;
      vecs.push_back(v);
   endfunction

   initial begin
      rst = 1'b0; en = 1'b0; mode = 2'b00; load_val = 4'd0;

      // reset with counting requested, then release
      add("rst_hold0",   0, 1, 2'b01, 0, 5, 0, 0);
      add("rst_hold1",   0, 1, 2'b01, 0, 5, 0, 0);
      add("rst_release", 1, 1, 2'b01, 0, 6, 0, 0);
      // up wrap from 14
      add("load14",      1, 1, 2'b11, 14, 14, 0, 0);
      add("up_to15",     1, 1, 2'b01, 0, 15, 0, 1);
      add("up_wrap",     1, 1, 2'b01, 0, SAT ? 15 : 0, 1, SAT ? 1 : 0);
      add("up_after",    1, 1, 2'b01, 0, SAT ? 15 : 1, SAT ? 1 : 0, SAT ? 1 : 0);
      // down wrap from 0 (load of a boundary raises no ovf)
      add("load0",       1, 1, 2'b11, 0, 0, 0, 0);
      add("down_wrap",   1, 1, 2'b10, 0, SAT ? 0 : 15, 1, SAT ? 1 : 0);
      add("hold_after",  1, 1, 2'b00, 0, SAT ? 0 : 15, 0, 0);
      // load and hold with en=0
      add("load9",       1, 1, 2'b11, 9, 9, 0, 0);
      for (int i = 0; i < 4; i++) add("en0_hold", 1, 0, 2'b01, 3, 9, 0, 0);
      // en=0 at terminal count: no step, no ovf
      add("load15",      1, 1, 2'b11, 15, 15, 0, 0);
      add("en0_at_tc",   1, 0, 2'b01, 0, 15, 0, 1);
      // reset mid-count, including at the boundary
      add("load6",       1, 1, 2'b11, 6, 6, 0, 0);
      add("up_to7",      1, 1, 2'b01, 0, 7, 0, 0);
      add("rst_mid",     0, 1, 2'b01, 0, 5, 0, 0);
      add("resume",      1, 1, 2'b01, 0, 6, 0, 0);
      add("load15b",     1, 1, 2'b11, 15, 15, 0, 0);
      add("rst_at_tc",   0, 1, 2'b01, 0, 5, 0, 0);
      // mode switching from 3
      add("load3",       1, 1, 2'b11, 3, 3, 0, 0);
      add("sw_up1",      1, 1, 2'b01, 0, 4, 0, 0);
      add("sw_up2",      1, 1, 2'b01, 0, 5, 0, 0);
      add("sw_down",     1, 1, 2'b10, 0, 4, 0, 0);
      add("sw_load12",   1, 1, 2'b11, 12, 12, 0, 0);
      add("sw_hold",     1, 1, 2'b00, 7, 12, 0, 0);

      foreach (vecs[i]) begin
         step(vecs[i].rst, vecs[i].en, vecs[i].mode, vecs[i].lv);
         check({vecs[i].name, ".q"},   int'(q),   vecs[i].exp_q);
         check({vecs[i].name, ".ovf"}, int'(ovf), vecs[i].exp_ovf);
         check({vecs[i].name, ".tc"},  int'(tc),  vecs[i].exp_tc);
      end

      // tc is combinational: it follows a mode change before any edge
      step(1, 1, 2'b11, 4'd0);
      mode = 2'b10; #1 check("tc_down_at0", int'(tc), 1);
      mode = 2'b01; #1 check("tc_up_at0",   int'(tc), 0);
      mode = 2'b11; #1 check("tc_load_at0", int'(tc), 0);
      mode = 2'b00; #1 check("tc_hold_at0", int'(tc), 0);
      step(1, 1, 2'b11, 4'd15);
      mode = 2'b01; #1 check("tc_up_at15",   int'(tc), 1);
      mode = 2'b10; #1 check("tc_down_at15", int'(tc), 0);
      // tc during reset follows RESET_VAL and mode
      step(0, 1, 2'b10, 4'd0);
      check("tc_in_rst", int'(tc), 0);
      check("q_in_rst",  int'(q),  RV);

      // randomized run against the reference model
      for (int n = 0; n < 600; n++) begin
         logic       r;
         logic       e;
         logic [1:0] m;
         logic [3:0] lv;
         r  = ($urandom_range(0, 31) != 0);
         e  = ($urandom_range(0, 4) != 0);
         m  = 2'($urandom_range(0, 3));
         lv = 4'($urandom_range(0, 15));
         // bias loads toward the boundaries to exercise wrap/saturate
         if (m == 2'b11 && $urandom_range(0, 1) == 1) lv = ($urandom_range(0, 1) == 1) ? 4'd15 : 4'd0;
         step(r, e, m, lv);
         check("rnd.q",   int'(q),   q_m);
         check("rnd.ovf", int'(ovf), ovf_m);
         check("rnd.tc",  int'(tc),  model_tc(q_m, int'(m)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_jk_counter

// File: doc/jk_counter.md
JK_COUNTER -- requirements
Module: jk_counter

Interface
- REQ-001 SHALL have parameter WIDTH, default 4, meaning counter bit width (legal range 2..32).
- REQ-002 SHALL have parameter RESET_VAL, default 0, meaning the value q takes on reset (WIDTH bits).
- REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
- REQ-004 SHALL have port rst  input  1  reset, synchronous and active-low.
- REQ-005 SHALL have port en  input  1  count enable; 0 forces hold regardless of mode.
- REQ-006 SHALL have port mode  input  2  operation select: 00 hold, 01 up, 10 down, 11 load.
- REQ-007 SHALL have port load_val  input  WIDTH  parallel load value, used in mode 11.
- REQ-008 SHALL have port q  output  WIDTH  registered counter value.
- REQ-009 SHALL have port tc  output  1  terminal count, combinational from q and mode.
- REQ-010 SHALL have port ovf  output  1  registered one-cycle wrap/limit pulse.

Function
- REQ-011 SHALL build every bit of q from one JK cell; the next state is computed only through per-bit J/K drive: hold J=K=0, toggle J=K=1, load J=load_val[i] with K=~load_val[i].
- REQ-012 SHALL, with en=1 and mode=01, toggle bit i when all lower bits are 1, giving q+1 mod 2^WIDTH one cycle later.
- REQ-013 SHALL, with en=1 and mode=10, toggle bit i when all lower bits are 0, giving q-1 mod 2^WIDTH one cycle later.
- REQ-014 SHALL, with en=1 and mode=11, present load_val on q one cycle later.
- REQ-015 SHALL leave q unchanged when en=0 or mode=00, and SHALL hold ovf at 0 in that cycle.
- REQ-016 SHALL drive tc=1 when mode=01 and q=2^WIDTH-1, or when mode=10 and q=0; tc SHALL be 0 otherwise, including in modes 00 and 11.
- REQ-017 SHALL assert ovf for exactly one cycle, in the cycle after any enabled step taken with tc=1.
- REQ-018 SHALL NOT assert ovf for a load, even when the loaded value equals a boundary.
- REQ-019 SHALL act on a mode change on the very next edge, with no pipeline stage and no lost cycle.

Reset
- REQ-020 SHALL, on a rising clk edge with rst=0, set q=RESET_VAL and ovf=0, overriding en, mode and load_val.
- REQ-021 SHALL give reset priority over any operation in progress; counting SHALL resume from RESET_VAL on the first edge with rst=1.
- REQ-022 SHALL keep tc derived only from q and mode, so tc follows RESET_VAL and mode during reset.

Configuration
- REQ-023 SHALL support the macro JK_COUNTER_SAT_EN.
  - Defined: an enabled up step at 2^WIDTH-1, or an enabled down step at 0, SHALL drive J=K=0 on all bits, so q saturates; ovf SHALL still pulse one cycle.
  - Undefined: q SHALL wrap as in REQ-012 and REQ-013.

Structure
- REQ-024 SHALL place the mode encodings (MODE_HOLD, MODE_UP, MODE_DOWN, MODE_LOAD) and the 2-bit mode type in shared package jk_pkg.
- REQ-025 SHALL instantiate WIDTH copies of sub-module jk_cell (clk, rst, ce, j, k, q; synchronous active-low reset to a per-instance reset bit; J/K truth table hold/reset/set/toggle).

Verification
- REQ-026 SHALL cover reset: WIDTH=4, RESET_VAL=5, rst=0 for 2 edges with mode=01 and en=1 -> q=5, ovf=0; first edge after rst=1 -> q=6.
- REQ-027 SHALL cover up wrap: q=14, mode=01, en=1 for 3 edges -> q=15 with tc=1, then q=0 with ovf=1 for one cycle, then q=1 with ovf=0.
- REQ-028 SHALL cover down wrap: load 0, then mode=10 -> tc=1, next q=15 with ovf=1; with JK_COUNTER_SAT_EN defined, q stays 0 and ovf=1 for one cycle.
- REQ-029 SHALL cover load and hold: mode=11 with load_val=9 -> q=9, ovf=0; en=0 with mode=01 for 4 edges -> q stays 9.
- REQ-030 SHALL cover reset mid-count: counting up at q=7, rst=0 for one edge -> q=RESET_VAL on that edge, with no ovf.
- REQ-031 SHALL cover mode switching: q=3 with mode sequence 01,01,10,11(load_val=12),00 -> q=4,5,4,12,12.
